// File: rtl/wave_sequencer.sv
// Steps a phase count through each enabled waveform for PERIODS sweeps and
// registers the selected sample. Define WAVE_SEQ_LOOP_EN to cycle through the waveforms forever.
module wave_sequencer #(
    parameter int PERIODS   = 10,
    parameter int NUM_WAVES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] freq_div,
    input  logic [5:0] wave_mask,
    input  logic [7:0] w0,
    input  logic [7:0] w1,
    input  logic [7:0] w2,
    input  logic [7:0] w3,
    input  logic [7:0] w4,
    input  logic [7:0] w5,
    output logic [7:0] count_num,
    output logic [2:0] wave_sel,
    output logic [7:0] wave_out,
    output logic       busy,
    output logic       period_tick,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] div_cnt;
    logic [7:0] period_cnt;
    logic [7:0] freq_div_lat;
    logic [5:0] mask_lat;

    logic [7:0] div_cnt_next;
    logic [7:0] count_num_next;
    logic [7:0] period_cnt_next;
    logic [7:0] freq_div_lat_next;
    logic [5:0] mask_lat_next;
    logic [2:0] wave_sel_next;
    logic       period_tick_next;

    logic [3:0] lowest;
    logic [3:0] higher;
`ifdef WAVE_SEQ_LOOP_EN
    logic [3:0] wrap_first;
`endif
    logic [7:0] sample;

    // Returns {found, index} of the lowest set mask bit at or above floor_idx.
    function automatic logic [3:0] first_enabled(input logic [5:0] mask, input int floor_idx);
        logic [3:0] result;
        result = 4'd0;
        for (int i = NUM_WAVES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= floor_idx)) begin
                result = {1'b1, 3'(i)};
            end
        end
        return result;
    endfunction

    always_comb begin
        sample = 8'd0;
        case (wave_sel)
            3'd0:    sample = w0;
            3'd1:    sample = w1;
            3'd2:    sample = w2;
            3'd3:    sample = w3;
            3'd4:    sample = w4;
            3'd5:    sample = w5;
            default: sample = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides everything; otherwise RUN advances the divider, the phase
    // count, the sweep counter and finally the waveform index, in that order.
    always_comb begin
        state_next        = state;
        div_cnt_next      = div_cnt;
        count_num_next    = count_num;
        period_cnt_next   = period_cnt;
        wave_sel_next     = wave_sel;
        freq_div_lat_next = freq_div_lat;
        mask_lat_next     = mask_lat;
        period_tick_next  = 1'b0;
        lowest            = first_enabled(wave_mask, 0);
        higher            = first_enabled(mask_lat, int'(wave_sel) + 1);
`ifdef WAVE_SEQ_LOOP_EN
        wrap_first        = first_enabled(mask_lat, 0);
`endif

        if (abort) begin
            state_next      = IDLE;
            div_cnt_next    = 8'd0;
            count_num_next  = 8'd0;
            period_cnt_next = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        freq_div_lat_next = freq_div;
                        mask_lat_next     = wave_mask;
                        div_cnt_next      = 8'd0;
                        count_num_next    = 8'd0;
                        period_cnt_next   = 8'd0;
                        if (lowest[3]) begin
                            wave_sel_next = lowest[2:0];
                            state_next    = RUN;
                        end else begin
                            state_next    = DONE;
                        end
                    end
                end

                RUN: begin
                    if (div_cnt == freq_div_lat) begin
                        div_cnt_next   = 8'd0;
                        count_num_next = count_num + 8'd1;
                        if (count_num == 8'hFF) begin
                            period_tick_next = 1'b1;
                            if (period_cnt == 8'(PERIODS - 1)) begin
                                period_cnt_next = 8'd0;
                                if (higher[3]) begin
                                    wave_sel_next = higher[2:0];
                                end else begin
`ifdef WAVE_SEQ_LOOP_EN
                                    wave_sel_next = wrap_first[2:0];
`else
                                    state_next    = DONE;
`endif
                                end
                            end else begin
                                period_cnt_next = period_cnt + 8'd1;
                            end
                        end
                    end else begin
                        div_cnt_next = div_cnt + 8'd1;
                    end
                end

                DONE: begin
                    state_next = IDLE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= 8'd0;
            count_num    <= 8'd0;
            period_cnt   <= 8'd0;
            wave_sel     <= 3'd0;
            freq_div_lat <= 8'd0;
            mask_lat     <= 6'd0;
            period_tick  <= 1'b0;
        end else begin
            div_cnt      <= div_cnt_next;
            count_num    <= count_num_next;
            period_cnt   <= period_cnt_next;
            wave_sel     <= wave_sel_next;
            freq_div_lat <= freq_div_lat_next;
            mask_lat     <= mask_lat_next;
            period_tick  <= period_tick_next;
        end
    end

    // The sample follows the index held before the edge, so it lags wave_sel by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wave_out <= 8'd0;
        end else if (state != IDLE) begin
            wave_out <= sample;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_wave_sequencer.sv
// Randomised and directed bench for wave_sequencer against an elapsed-cycle
// reference model; honours WAVE_SEQ_LOOP_EN the same way the design does.
module tb_wave_sequencer;

    localparam int PERIODS = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] freq_div;
    logic [5:0] wave_mask;
    logic [7:0] wv [6];
    logic [7:0] count_num;
    logic [2:0] wave_sel;
    logic [7:0] wave_out;
    logic       busy;
    logic       period_tick;
    logic       done;

    int compared;
    int mismatched;

    // Reference model: sequence progress derived from cycles elapsed in RUN.
    bit         m_run;
    bit         m_done;
    bit         m_tick;
    int         m_n;
    int         m_fd;
    int         m_list [$];
    logic [2:0] m_sel;
    logic [7:0] m_wave_out;

    // Observations gathered per directed scenario.
    int         obs_cycles;
    int         obs_busy;
    int         obs_ticks;
    int         obs_done;
    int         obs_first_tick;
    logic [2:0] obs_seq [$];

    wave_sequencer #(.PERIODS(PERIODS), .NUM_WAVES(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .freq_div   (freq_div),
        .wave_mask  (wave_mask),
        .w0         (wv[0]),
        .w1         (wv[1]),
        .w2         (wv[2]),
        .w3         (wv[3]),
        .w4         (wv[4]),
        .w5         (wv[5]),
        .count_num  (count_num),
        .wave_sel   (wave_sel),
        .wave_out   (wave_out),
        .busy       (busy),
        .period_tick(period_tick),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_run      = 1'b0;
        m_done     = 1'b0;
        m_tick     = 1'b0;
        m_n        = 0;
        m_fd       = 0;
        m_sel      = 3'd0;
        m_wave_out = 8'd0;
        m_list.delete();
    endtask

    task automatic modelEdge();
        int steps;
        int slot;
        if (m_run || m_done) m_wave_out = wv[m_sel];
        m_tick = 1'b0;
        if (abort) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_run) begin
            m_n++;
            steps = m_n / (m_fd + 1);
            if ((m_n % (m_fd + 1)) == 0 && (steps % 256) == 0) m_tick = 1'b1;
            slot = steps / (256 * PERIODS);
`ifdef WAVE_SEQ_LOOP_EN
            m_sel = 3'(m_list[slot % m_list.size()]);
`else
            if (slot >= m_list.size()) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_sel = 3'(m_list[slot]);
            end
`endif
        end else if (start) begin
            m_list.delete();
            for (int i = 0; i < 6; i++) if (wave_mask[i]) m_list.push_back(i);
            m_fd = int'(freq_div);
            m_n  = 0;
            if (m_list.size() == 0) begin
                m_done = 1'b1;
            end else begin
                m_run = 1'b1;
                m_sel = 3'(m_list[0]);
            end
        end
    endtask

    task automatic compareAll();
        logic [7:0] exp_cnt;
        exp_cnt = m_run ? 8'((m_n / (m_fd + 1)) % 256) : 8'd0;
        checkOutput("count_num", 32'(count_num), 32'(exp_cnt));
        checkOutput("wave_sel", 32'(wave_sel), 32'(m_sel));
        checkOutput("wave_out", 32'(wave_out), 32'(m_wave_out));
        checkOutput("busy", 32'(busy), 32'(m_run));
        checkOutput("period_tick", 32'(period_tick), 32'(m_tick));
        checkOutput("done", 32'(done), 32'(m_done));
    endtask

    task automatic clearObservers();
        obs_cycles     = 0;
        obs_busy       = 0;
        obs_ticks      = 0;
        obs_done       = 0;
        obs_first_tick = -1;
        obs_seq.delete();
    endtask

    // Drives one cycle of control inputs with fresh samples, then checks after the edge.
    task automatic applyStimulus(input bit start_v, input bit abort_v);
        start = start_v;
        abort = abort_v;
        for (int i = 0; i < 6; i++) wv[i] = 8'($urandom);
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
        obs_cycles++;
        if (busy === 1'b1) obs_busy++;
        if (period_tick === 1'b1) begin
            obs_ticks++;
            if (obs_first_tick < 0) obs_first_tick = obs_cycles;
        end
        if (done === 1'b1) obs_done++;
        if (busy === 1'b1 && (obs_seq.size() == 0 || obs_seq[$] != wave_sel)) obs_seq.push_back(wave_sel);
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        while ((m_run || m_done) && n < budget) begin
            freq_div  = 8'($urandom);
            wave_mask = 6'($urandom);
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        if (m_run || m_done) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int start_cycle;
        int n;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        freq_div   = 8'd0;
        wave_mask  = 6'd0;
        for (int i = 0; i < 6; i++) wv[i] = 8'd0;
        modelReset();
        clearObservers();

        #1;
        compareAll();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);

`ifndef WAVE_SEQ_LOOP_EN
        $display("[TB] single waveform, divider 0");
        clearObservers();
        freq_div  = 8'd0;
        wave_mask = 6'b000001;
        applyStimulus(1'b1, 1'b0);
        runUntilIdle(3000);
        checkOutput("single_busy_cycles", 32'(obs_busy), 32'd2560);
        checkOutput("single_ticks", 32'(obs_ticks), 32'd10);
        checkOutput("single_done_cycles", 32'(obs_done), 32'd1);

        $display("[TB] three waveforms 0,2,5");
        clearObservers();
        freq_div  = 8'd0;
        wave_mask = 6'b100101;
        applyStimulus(1'b1, 1'b0);
        runUntilIdle(8000);
        checkOutput("multi_busy_cycles", 32'(obs_busy), 32'd7680);
        checkOutput("multi_seq_len", 32'(obs_seq.size()), 32'd3);
        if (obs_seq.size() == 3) begin
            checkOutput("multi_seq0", 32'(obs_seq[0]), 32'd0);
            checkOutput("multi_seq1", 32'(obs_seq[1]), 32'd2);
            checkOutput("multi_seq2", 32'(obs_seq[2]), 32'd5);
        end
`else
        $display("[TB] looping over waveforms 0,1");
        clearObservers();
        freq_div  = 8'd0;
        wave_mask = 6'b000011;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 4 * 2560 + 5; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("loop_done_cycles", 32'(obs_done), 32'd0);
        checkOutput("loop_seq_len", 32'(obs_seq.size()), 32'd5);
        for (int i = 0; i < obs_seq.size(); i++) checkOutput("loop_seq", 32'(obs_seq[i]), 32'(i % 2));
        applyStimulus(1'b0, 1'b1);
        checkOutput("loop_abort_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] divider 3, first period tick");
        clearObservers();
        freq_div  = 8'd3;
        wave_mask = 6'b000001;
        applyStimulus(1'b1, 1'b0);
        start_cycle = obs_cycles;
        n = 0;
        while (obs_first_tick < 0 && n < 1100) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("first_tick_delay", 32'(obs_first_tick - start_cycle), 32'd1024);
        applyStimulus(1'b0, 1'b1);

        $display("[TB] abort at count 100, ignored restart");
        clearObservers();
        freq_div  = 8'd0;
        wave_mask = 6'b000001;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 50; c++) applyStimulus(1'b0, 1'b0);
        wave_mask = 6'b100000;
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (count_num !== 8'd100 && n < 300) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("reach_count_100", 32'(count_num), 32'd100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_count", 32'(count_num), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_no_done", 32'(obs_done), 32'd0);

        $display("[TB] empty mask start");
        wave_mask = 6'd0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("empty_done", 32'(done), 32'd1);
        checkOutput("empty_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("empty_done_cleared", 32'(done), 32'd0);

        $display("[TB] reset mid-run");
        freq_div  = 8'd0;
        wave_mask = 6'b010010;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 300; c++) applyStimulus(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count_num), 32'd0);
        checkOutput("rst_sel", 32'(wave_sel), 32'd0);
        checkOutput("rst_wave_out", 32'(wave_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_tick", 32'(period_tick), 32'd0);
        modelReset();
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0);

        $display("[TB] random stimulus");
        for (int c = 0; c < 20000; c++) begin
            freq_div  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            wave_mask = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter PERIODS, default 10: full count_num sweeps per waveform, range 1..255.
REQ-002 SHALL have parameter NUM_WAVES, default 6: number of selectable waveforms, fixed at 6.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse that begins a sequence from IDLE.
REQ-006 SHALL have port abort  input  1: returns the block to IDLE from any state.
REQ-007 SHALL have port freq_div  input  8: step divider; count_num advances every freq_div+1 cycles.
REQ-008 SHALL have port wave_mask  input  6: bit n set enables waveform n; bit order 0=square, 1=reciprocal, 2=triangle, 3=sin, 4=full-wave rectified, 5=half-wave rectified.
REQ-009 SHALL have ports w0..w5  input  8 each: sample buses from the waveform generator, same bit order as wave_mask.
REQ-010 SHALL have port count_num  output  8: phase count driven to the waveform generator.
REQ-011 SHALL have port wave_sel  output  3: index of the active waveform.
REQ-012 SHALL have port wave_out  output  8: registered sample of the selected waveform.
REQ-013 SHALL have port busy  output  1: high in RUN.
REQ-014 SHALL have port period_tick  output  1: one-cycle pulse when count_num wraps 255->0.
REQ-015 SHALL have port done  output  1: one-cycle pulse when a sequence completes.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1 and latched mask nonzero, latch freq_div and wave_mask, load wave_sel with the lowest enabled index and count_num=0, then enter RUN.
REQ-018 SHALL, when start=1 with wave_mask=0, go IDLE->DONE->IDLE, asserting done one cycle with busy never high.
REQ-019 SHALL, in RUN, use an 8-bit divider counter 0..freq_div; at terminal count it clears and count_num increments mod 256; freq_div=0 steps every cycle.
REQ-020 SHALL, on a count_num step from 255 to 0, pulse period_tick and increment the period counter.
REQ-021 SHALL, when the period counter reaches PERIODS, clear it and move wave_sel to the next higher enabled index.
REQ-022 SHALL, with no higher enabled index, enter DONE; DONE lasts exactly one cycle (done=1), then IDLE.
REQ-023 SHALL set wave_out at each rising edge to the w input selected by the current wave_sel (one-cycle latency), and hold wave_out in IDLE.
REQ-024 SHALL ignore start outside IDLE, and ignore changes to freq_div/wave_mask after latching.
REQ-025 SHALL give abort priority over start and all sequencing: next state IDLE, count_num=0, counters cleared, no done pulse.
REQ-026 SHALL assert busy combinationally from state==RUN.

Reset
REQ-027 SHALL, on rst=0, asynchronously force state IDLE, count_num=0, wave_sel=0, wave_out=0, busy=0, done=0, period_tick=0, divider and period counters=0, latched mask/divider=0.
REQ-028 SHALL, on reset asserted mid-RUN, abandon the sequence with no done pulse; operation resumes only on a new start after release.

Configuration
REQ-029 SHALL recognise macro WAVE_SEQ_LOOP_EN: when defined, after the last enabled waveform RUN wraps to the lowest enabled index, DONE is never entered, done stays 0, and only abort or reset exits; when undefined, behaviour is per REQ-022.

Verification
REQ-030 SHALL cover: freq_div=0, wave_mask=6'b000001, start -> busy for exactly 2560 cycles, 10 period_tick pulses, then done for 1 cycle.
REQ-031 SHALL cover: freq_div=3, wave_mask=6'b000001 -> count_num steps every 4 cycles; first period_tick 1024 cycles after entering RUN.
REQ-032 SHALL cover: wave_mask=6'b100101, freq_div=0 -> wave_sel sequence 0,2,5 with 2560 cycles each; wave_out equals the w0/w2/w5 value one cycle later.
REQ-033 SHALL cover: abort at count_num=100 of wave 0 -> IDLE next cycle, count_num=0, busy=0, no done; second start mid-RUN is ignored.
REQ-034 SHALL cover: wave_mask=0 start -> done pulse with busy=0; rst low mid-RUN -> all outputs 0 immediately without a clock edge.
REQ-035 SHALL cover: with WAVE_SEQ_LOOP_EN, mask 6'b000011 -> wave_sel 0,1,0,1... with no done over 4 waveform slots.
